serial_cmd_master: RTL and testbench
====================================

// Module: serial_cmd_master
// PURPOSE
//  Command initiator for the byte-serial board control protocol: serializes one command (opcode + 0..MAX_ARGS
//  argument bytes) onto a UART transmitter, then collects a fixed-length reply from the UART receiver.
//  Stores the reply as little-endian 32-bit words for readout. Sits between a local controller and UART tx/rx.
//  Drives remote trigger boards' command processors: version, deadticks, masks, histogram dump, etc.
// PARAMETERS
//  MAX_ARGS        4        max argument bytes per command (cmd_nargs 0..MAX_ARGS)
//  MAX_RESP        288      reply buffer depth in bytes (72 words; covers histogram dump)
//  TIMEOUT_CYCLES  5000000  idle clk cycles allowed between reply bytes (and before the first)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            synchronous, active-high reset
//  cmd_valid    in   1            command request; accepted when cmd_valid && cmd_ready
//  cmd_ready    out  1            high only in IDLE
//  cmd_opcode   in   8            command byte, sent first
//  cmd_nargs    in   4            argument byte count; values > MAX_ARGS clamp to MAX_ARGS
//  cmd_args     in   8*MAX_ARGS   arg byte k at [8k+7:8k], sent k=0 first
//  cmd_nresp    in   9            expected reply bytes; values > MAX_RESP clamp to MAX_RESP
//  txBusy       in   1            UART transmitter busy
//  txStart      out  1            one-cycle strobe, loads txData
//  txData       out  8            byte to transmit
//  rxReady      in   1            one-cycle strobe, rxData valid
//  rxData       in   8            received byte
//  resp_addr    in   7            word index into reply buffer
//  resp_word    out  32           {byte[4a+3],byte[4a+2],byte[4a+1],byte[4a]}; registered, 1-cycle latency
//  resp_count   out  9            bytes received for last command
//  done         out  1            one-cycle pulse at command completion
//  timeout      out  1            sticky: last command timed out; cleared on next accept
// BEHAVIOUR
//  Reset: cmd_ready=0 in the reset cycle, then 1; txStart=0, txData=0, done=0, timeout=0, resp_count=0,
//   resp_word=0; state=IDLE. Buffer contents undefined after reset.
//  States: IDLE, TX_WAIT, TX_GAP, RX, DONE.
//  IDLE: on accept, latch opcode/args/nargs/nresp; clear resp_count and timeout -> TX_WAIT, byte index 0.
//  TX_WAIT: when !txBusy drive txData=current byte, txStart=1 for exactly one cycle -> TX_GAP.
//   Held in TX_WAIT indefinitely while txBusy=1 (no timeout on tx side).
//  TX_GAP: txStart=0 (one mandatory idle cycle so txBusy can assert). If bytes sent < 1+nargs -> TX_WAIT;
//   else nresp==0 -> DONE, otherwise -> RX with timer cleared.
//  RX: rxReady writes rxData at byte address resp_count, resp_count+1, timer cleared. When resp_count reaches
//   nresp -> DONE. Timer reaching TIMEOUT_CYCLES with no byte -> timeout=1 -> DONE (partial count kept).
//  DONE: done=1 for one cycle -> IDLE. rxReady in DONE is discarded.
//  rxReady outside RX (IDLE, TX_WAIT, TX_GAP, DONE) discarded; no buffer write, no count change.
//  Byte accepted in RX on the same cycle the timer expires: byte wins, timer clears, no timeout.
//  Minimum latency, nargs=0, nresp=0: accept at cycle 0, txStart cycle 1, done cycle 3.
//  Reset mid-command: aborts immediately; txStart forced 0 same edge; partial reply discarded (resp_count=0).
//  resp_word readable in any state; reads of bytes >= resp_count return stale/undefined data.
//  resp_addr >= MAX_RESP/4 returns 0.
//  Timer width: $clog2(TIMEOUT_CYCLES+1); no wrap (saturates at expiry).
// STRUCTURE
//  Package serial_cmd_pkg: opcode constants CMD_VERSION=0, CMD_DEADTICKS=1, CMD_FIRINGTICKS=2, CMD_TOGGLE_EN=3,
//   CMD_TOGGLE_CLKSRC=4, CMD_SET_PHASE=5, CMD_MASK1=6, CMD_MASK2=7, CMD_PASSTHRU=8, CMD_READ_HIST=10,
//   CMD_TOGGLE_VETO=11, CMD_RESET_PLL=13, CMD_VETO_CYCLES=14, CMD_CLK_AS_INPUT=15; HIST_RESP_BYTES=288;
//   state enum type.
//  Sub-module serial_resp_buffer: MAX_RESP-byte RAM, byte write port, registered 32-bit word read port.
// TESTING
//  1 Version: opcode 0x00, nargs 0, nresp 1; after txStart model replies 0x10 -> tx stream {00}, done,
//    resp_count=1, resp_word(0)[7:0]=0x10, timeout=0.
//  2 Arg write: opcode 0x01, nargs 1, args 0x0A, nresp 0 -> tx stream {01,0A}, txStart pulses >=2 cycles
//    apart, done 2 cycles after last txStart, no RX wait.
//  3 Histogram: opcode 0x0A, nresp 288, model returns bytes i mod 256 -> resp_count=288,
//    resp_word(1)=0x07060504, resp_word(71)=0x1F1E1D1C.
//  4 Back-pressure: hold txBusy=1 for 50 cycles after first byte, nargs 2 -> no txStart while busy,
//    stream {opcode,a0,a1} intact and in order.
//  5 Timeout: TIMEOUT_CYCLES=100, nresp 4, model sends 2 bytes then stops -> done after 100 idle cycles,
//    timeout=1, resp_count=2; next accept clears timeout.
//  6 Reset mid-RX after 3 of 8 bytes -> txStart=0, cmd_ready=1 next cycle, resp_count=0;
//    stray rxReady while IDLE -> no count change.

Source files
------------

// File: rtl/serial_cmd_master_pkg.sv
// serial_cmd_pkg: opcodes, reply sizes and FSM state type shared
// by the serial command master, its reply buffer and benches.
package serial_cmd_pkg;

  localparam logic [7:0] CMD_VERSION       = 8'd0;
  localparam logic [7:0] CMD_DEADTICKS     = 8'd1;
  localparam logic [7:0] CMD_FIRINGTICKS   = 8'd2;
  localparam logic [7:0] CMD_TOGGLE_EN     = 8'd3;
  localparam logic [7:0] CMD_TOGGLE_CLKSRC = 8'd4;
  localparam logic [7:0] CMD_SET_PHASE     = 8'd5;
  localparam logic [7:0] CMD_MASK1         = 8'd6;
  localparam logic [7:0] CMD_MASK2         = 8'd7;
  localparam logic [7:0] CMD_PASSTHRU      = 8'd8;
  localparam logic [7:0] CMD_READ_HIST     = 8'd10;
  localparam logic [7:0] CMD_TOGGLE_VETO   = 8'd11;
  localparam logic [7:0] CMD_RESET_PLL     = 8'd13;
  localparam logic [7:0] CMD_VETO_CYCLES   = 8'd14;
  localparam logic [7:0] CMD_CLK_AS_INPUT  = 8'd15;

  localparam int HIST_RESP_BYTES = 288;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_WAIT,
    ST_TX_GAP,
    ST_RX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/serial_cmd_master_if.sv
// serial_cmd_master_if: command, UART tx/rx and reply readout bus.
// master = command master side, slave = controller/UART side.
interface serial_cmd_master_if #(
  parameter int MAX_ARGS = 4
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [7:0]              cmd_opcode;
  logic [3:0]              cmd_nargs;
  logic [8*MAX_ARGS-1:0]   cmd_args;
  logic [8:0]              cmd_nresp;
  logic                    txBusy;
  logic                    txStart;
  logic [7:0]              txData;
  logic                    rxReady;
  logic [7:0]              rxData;
  logic [6:0]              resp_addr;
  logic [31:0]             resp_word;
  logic [8:0]              resp_count;
  logic                    done;
  logic                    timeout;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_nargs,
    input  cmd_args, cmd_nresp,
    input  txBusy, rxReady, rxData, resp_addr,
    output cmd_ready, txStart, txData,
    output resp_word, resp_count, done, timeout
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_nargs,
    output cmd_args, cmd_nresp,
    output txBusy, rxReady, rxData, resp_addr,
    input  cmd_ready, txStart, txData,
    input  resp_word, resp_count, done, timeout
  );

endinterface

// File: rtl/serial_resp_buffer.sv
// serial_resp_buffer: MAX_RESP-byte reply RAM. Ports: clk, reset,
// we/waddr/wdata byte write, raddr word read -> rdata (1-cycle).
module serial_resp_buffer #(
  parameter int MAX_RESP = 288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [8:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic [6:0]  raddr,
  output logic [31:0] rdata
);

  localparam int WORDS = MAX_RESP / 4;

  logic [7:0]  mem_q [MAX_RESP];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;
  logic [8:0]  base;

  // Little-endian word: lowest byte address in bits [7:0].
  always_comb begin
    base    = {raddr, 2'b00};
    rdata_d = '0;
    if (int'(raddr) < WORDS) begin
      rdata_d = {mem_q[base + 9'd3],
                 mem_q[base + 9'd2],
                 mem_q[base + 9'd1],
                 mem_q[base]};
    end
  end

  always_ff @(posedge clk) begin
    if (we && int'(waddr) < MAX_RESP) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/serial_cmd_master.sv
// serial_cmd_master: sends opcode + args over UART tx, collects a
// fixed-length reply from UART rx. Ports: clk, reset, bus (master).
module serial_cmd_master
  import serial_cmd_pkg::*;
#(
  parameter int MAX_ARGS       = 4,
  parameter int MAX_RESP       = HIST_RESP_BYTES,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input logic                 clk,
  input logic                 reset,
  serial_cmd_master_if.master bus
);

  localparam int CW = $clog2(MAX_ARGS + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = 8 * (MAX_ARGS + 1);

  state_e          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [BW-1:0]   tx_buf_q, tx_buf_d;
  logic [CW-1:0]   sent_q, sent_d;
  logic [CW-1:0]   nargs_q, nargs_d;
  logic [8:0]      nresp_q, nresp_d;
  logic [8:0]      count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   timer_inc;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            buf_we;
  logic [31:0]     resp_word;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_buf_d    = tx_buf_q;
    sent_d      = sent_q;
    nargs_d     = nargs_q;
    nresp_d     = nresp_q;
    count_d     = count_q;
    timer_d     = timer_q;
    timer_inc   = timer_q + 1'b1;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    buf_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          tx_buf_d    = {bus.cmd_args, bus.cmd_opcode};
          sent_d      = '0;
          nargs_d     = (int'(bus.cmd_nargs) > MAX_ARGS)
                      ? CW'(MAX_ARGS) : CW'(bus.cmd_nargs);
          nresp_d     = (int'(bus.cmd_nresp) > MAX_RESP)
                      ? 9'(MAX_RESP) : bus.cmd_nresp;
          count_d     = '0;
          timeout_d   = 1'b0;
          state_d     = ST_TX_WAIT;
          // Launch straight away when the UART is free so the
          // first byte leaves the cycle after accept.
          if (!bus.txBusy) begin
            tx_start_d = 1'b1;
            tx_data_d  = bus.cmd_opcode;
          end
        end
      end

      // tx_start_q high here means the strobe is on the wire now.
      ST_TX_WAIT: begin
        if (tx_start_q) begin
          tx_buf_d = tx_buf_q >> 8;
          sent_d   = sent_q + 1'b1;
          state_d  = ST_TX_GAP;
        end else if (!bus.txBusy) begin
          tx_start_d = 1'b1;
          tx_data_d  = tx_buf_q[7:0];
        end
      end

      ST_TX_GAP: begin
        if (sent_q <= nargs_q) begin
          state_d = ST_TX_WAIT;
          if (!bus.txBusy) begin
            tx_start_d = 1'b1;
            tx_data_d  = tx_buf_q[7:0];
          end
        end else if (nresp_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RX;
          timer_d = '0;
        end
      end

      // A byte arriving on the expiry cycle wins over the timer.
      ST_RX: begin
        if (bus.rxReady) begin
          buf_we  = 1'b1;
          count_d = count_q + 9'd1;
          timer_d = '0;
          if (count_q + 9'd1 == nresp_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else if (timer_inc == TW'(TIMEOUT_CYCLES)) begin
          timer_d   = timer_inc;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
          done_d    = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_buf_q    <= '0;
      sent_q      <= '0;
      nargs_q     <= '0;
      nresp_q     <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      tx_buf_q    <= tx_buf_d;
      sent_q      <= sent_d;
      nargs_q     <= nargs_d;
      nresp_q     <= nresp_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  serial_resp_buffer #(
    .MAX_RESP (MAX_RESP)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we && !reset),
    .waddr (count_q),
    .wdata (bus.rxData),
    .raddr (bus.resp_addr),
    .rdata (resp_word)
  );

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.txStart    = tx_start_q;
  assign bus.txData     = tx_data_q;
  assign bus.resp_word  = resp_word;
  assign bus.resp_count = count_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_serial_cmd_master.sv
// tb_serial_cmd_master: directed bench with tx byte scoreboard,
// reply word scoreboard and a busy-modelling UART tx stub.
module tb_serial_cmd_master;
  import serial_cmd_pkg::*;

  localparam int TO = 100;

  typedef struct {
    int          addr;
    logic [31:0] w;
  } ew_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [7:0] exp_tx[$];
  ew_t        exp_w[$];
  int         ts_q[$];
  int busy_len = 2;
  int busy_cnt = 0;
  int busy_viol = 0;
  int extra_tx = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  int rx_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_cmd_master_if #(.MAX_ARGS(4)) bus ();

  serial_cmd_master #(
    .MAX_ARGS       (4),
    .MAX_RESP       (288),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  // UART tx stub: scoreboards each byte, then holds txBusy.
  initial begin
    bus.txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.txStart) begin
        ts_q.push_back(cyc);
        if (bus.txBusy) busy_viol++;
        if (exp_tx.size() == 0) extra_tx++;
        else chk("tx_byte", {24'd0, bus.txData},
                 {24'd0, exp_tx.pop_front()});
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      bus.txBusy = (busy_cnt != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] op, input logic [3:0] na,
                       input logic [31:0] args,
                       input logic [8:0] nr);
    int k = 0;
    int lim;
    while (!bus.cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    lim = (int'(na) > 4) ? 4 : int'(na);
    exp_tx.push_back(op);
    for (int i = 0; i < lim; i++) exp_tx.push_back(args[8*i +: 8]);
    bus.cmd_opcode = op;
    bus.cmd_nargs  = na;
    bus.cmd_args   = args;
    bus.cmd_nresp  = nr;
    bus.cmd_valid  = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_tx();
    int k = 0;
    while (exp_tx.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("tx_drain", exp_tx.size(), 0);
  endtask

  task automatic wait_done(input int n0, input int bound);
    int k = 0;
    while (done_cnt <= n0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'd0, done_cnt > n0}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rxData  = b;
    bus.rxReady = 1'b1;
    rx_cyc = cyc;
    @(negedge clk);
    bus.rxReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_word(input logic [6:0] a,
                           output logic [31:0] w);
    bus.resp_addr = a;
    @(negedge clk);
    w = bus.resp_word;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] acc;
    ew_t         e;
    int          n0;

    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_nargs  = '0;
    bus.cmd_args   = '0;
    bus.cmd_nresp  = '0;
    bus.rxReady    = 1'b0;
    bus.rxData     = '0;
    bus.resp_addr  = '0;

    // Reset state
    tick(3);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_txStart", {31'd0, bus.txStart}, 32'd0);
    chk("rst_txData", {24'd0, bus.txData}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    chk("rst_count", {23'd0, bus.resp_count}, 32'd0);
    chk("rst_word", bus.resp_word, 32'd0);
    reset = 1'b0;
    tick(1);
    chk("rst_ready_after", {31'd0, bus.cmd_ready}, 32'd1);

    // Version query, 1-byte reply
    n0 = done_cnt;
    issue(CMD_VERSION, 4'd0, 32'd0, 9'd1);
    wait_tx();
    tick(2);
    send_byte(8'h10);
    wait_done(n0, 50);
    chk("t1_count", {23'd0, bus.resp_count}, 32'd1);
    chk("t1_timeout", {31'd0, bus.timeout}, 32'd0);
    read_word(7'd0, w);
    chk("t1_word0", {24'd0, w[7:0]}, 32'h10);

    // Stray byte while idle is dropped
    send_byte(8'hEE);
    chk("idle_rx_count", {23'd0, bus.resp_count}, 32'd1);
    read_word(7'd0, w);
    chk("idle_rx_word", {24'd0, w[7:0]}, 32'h10);

    // Argument write, no reply
    ts_q.delete();
    n0 = done_cnt;
    issue(CMD_DEADTICKS, 4'd1, 32'h0000_000A, 9'd0);
    wait_done(n0, 50);
    chk("t2_ntx", ts_q.size(), 2);
    chk("t2_gap", {31'd0, (ts_q[1] - ts_q[0]) >= 2}, 32'd1);
    chk("t2_done_lat", done_cyc - ts_q[1], 2);

    // Minimum latency
    ts_q.delete();
    n0 = done_cnt;
    issue(CMD_TOGGLE_EN, 4'd0, 32'd0, 9'd0);
    wait_done(n0, 50);
    chk("min_tx_lat", ts_q[0] - acc_cyc, 1);
    chk("min_done_lat", done_cyc - acc_cyc, 3);

    // nargs above MAX_ARGS clamps to 4 argument bytes
    ts_q.delete();
    n0 = done_cnt;
    issue(CMD_PASSTHRU, 4'd9, 32'h4433_2211, 9'd0);
    wait_done(n0, 100);
    chk("clamp_ntx", ts_q.size(), 5);

    // Histogram dump, 288 bytes
    n0 = done_cnt;
    issue(CMD_READ_HIST, 4'd0, 32'd0, 9'd288);
    wait_tx();
    tick(2);
    acc = '0;
    for (int i = 0; i < 288; i++) begin
      acc[8*(i%4) +: 8] = 8'(i);
      if (i % 4 == 3) begin
        e.addr = i / 4;
        e.w    = acc;
        exp_w.push_back(e);
      end
      send_byte(8'(i));
    end
    wait_done(n0, 50);
    chk("t3_count", {23'd0, bus.resp_count}, 32'd288);
    chk("t3_timeout", {31'd0, bus.timeout}, 32'd0);
    while (exp_w.size() != 0) begin
      e = exp_w.pop_front();
      read_word(7'(e.addr), w);
      chk($sformatf("t3_word%0d", e.addr), w, e.w);
    end
    read_word(7'd1, w);
    chk("t3_w1", w, 32'h0706_0504);
    read_word(7'd71, w);
    chk("t3_w71", w, 32'h1F1E_1D1C);
    read_word(7'd72, w);
    chk("t3_w72_oob", w, 32'd0);
    read_word(7'd127, w);
    chk("t3_w127_oob", w, 32'd0);

    // Back-pressure: txBusy held 50 cycles per byte
    busy_len = 50;
    busy_viol = 0;
    ts_q.delete();
    n0 = done_cnt;
    issue(CMD_MASK1, 4'd2, 32'h0000_2211, 9'd0);
    wait_done(n0, 400);
    chk("t4_ntx", ts_q.size(), 3);
    chk("t4_gap0", {31'd0, (ts_q[1] - ts_q[0]) >= 50}, 32'd1);
    chk("t4_gap1", {31'd0, (ts_q[2] - ts_q[1]) >= 50}, 32'd1);
    chk("t4_busy_viol", busy_viol, 0);
    busy_len = 2;

    // Timeout after 2 of 4 reply bytes
    n0 = done_cnt;
    issue(CMD_VERSION, 4'd0, 32'd0, 9'd4);
    wait_tx();
    tick(2);
    send_byte(8'hA1);
    send_byte(8'hA2);
    wait_done(n0, 300);
    chk("t5_to_lat", done_cyc - rx_cyc, TO + 1);
    chk("t5_timeout", {31'd0, bus.timeout}, 32'd1);
    chk("t5_count", {23'd0, bus.resp_count}, 32'd2);
    read_word(7'd0, w);
    chk("t5_word0", {16'd0, w[15:0]}, 32'h0000_A2A1);
    n0 = done_cnt;
    issue(CMD_TOGGLE_VETO, 4'd0, 32'd0, 9'd0);
    chk("t5_to_clear", {31'd0, bus.timeout}, 32'd0);
    chk("t5_cnt_clear", {23'd0, bus.resp_count}, 32'd0);
    wait_done(n0, 50);

    // Reset after 3 of 8 reply bytes
    n0 = done_cnt;
    issue(CMD_VETO_CYCLES, 4'd0, 32'd0, 9'd8);
    wait_tx();
    tick(2);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    chk("t6_mid_count", {23'd0, bus.resp_count}, 32'd3);
    reset = 1'b1;
    tick(1);
    chk("t6_txStart", {31'd0, bus.txStart}, 32'd0);
    chk("t6_count", {23'd0, bus.resp_count}, 32'd0);
    chk("t6_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    tick(1);
    chk("t6_ready", {31'd0, bus.cmd_ready}, 32'd1);
    send_byte(8'h55);
    chk("t6_stray", {23'd0, bus.resp_count}, 32'd0);

    // Recovery after abort
    n0 = done_cnt;
    issue(CMD_RESET_PLL, 4'd0, 32'd0, 9'd1);
    wait_tx();
    tick(2);
    send_byte(8'h5A);
    wait_done(n0, 50);
    chk("t6_recover", {23'd0, bus.resp_count}, 32'd1);
    chk("extra_tx", extra_tx, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
